// File: rtl/mac_mgnt_pkg.sv
// mac_mgnt_pkg: shared types and defaults for the MAC management scheduler
package mac_mgnt_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {REQ_HOST, REQ_POLL} req_t;
    localparam int DEF_TIMEOUT = 63;
    localparam int DEF_POLL_PERIOD = 125000;
endpackage

// File: rtl/mac_mgnt_sched_if.sv
// mac_mgnt_sched_if: host, poller-result and per-port MAC register bus signals
interface mac_mgnt_sched_if #(
    parameter int NPORT = 4,
    parameter int PW = 2
);
    logic host_req_valid, host_req_ready, host_req_wr;
    logic [PW-1:0] host_req_port;
    logic [7:0] host_req_addr;
    logic host_resp_valid, host_resp_err;
    logic [7:0] host_resp_data;
    logic poll_en, poll_valid, poll_err;
    logic [PW-1:0] poll_port;
    logic [7:0] poll_addr, poll_data;
    logic [NPORT-1:0] sys_req_valid, sys_resp_valid;
    logic sys_req_wr;
    logic [7:0] sys_req_addr;
    logic [NPORT*8-1:0] sys_resp_data;
    modport master (
        input host_req_valid, host_req_wr, host_req_port, host_req_addr, poll_en,
              sys_resp_valid, sys_resp_data,
        output host_req_ready, host_resp_valid, host_resp_data, host_resp_err,
               poll_valid, poll_port, poll_addr, poll_data, poll_err,
               sys_req_valid, sys_req_wr, sys_req_addr
    );
    modport slave (
        output host_req_valid, host_req_wr, host_req_port, host_req_addr, poll_en,
               sys_resp_valid, sys_resp_data,
        input host_req_ready, host_resp_valid, host_resp_data, host_resp_err,
              poll_valid, poll_port, poll_addr, poll_data, poll_err,
              sys_req_valid, sys_req_wr, sys_req_addr
    );
endinterface

// File: rtl/mac_mgnt_poll_seq.sv
// mac_mgnt_poll_seq: periodic sweep generator walking every port/register pair
module mac_mgnt_poll_seq import mac_mgnt_pkg::*; #(
    parameter int NPORT = 4,
    parameter int PW = 2,
    parameter logic [7:0] POLL_BASE = 8'h00,
    parameter int POLL_CNT = 4,
    parameter int POLL_PERIOD = DEF_POLL_PERIOD
) (
    input  logic clk,
    input  logic rstn_sys,
    input  logic poll_en,
    input  logic item_take,
    input  logic sweep_abort,
    output logic item_valid,
    output logic [PW-1:0] item_port,
    output logic [7:0] item_addr
);
    localparam int CW = $clog2(POLL_PERIOD + 1);
    logic [CW-1:0] cnt;
    logic [7:0] idx;
    logic sweep_pend, wrap, last_idx, last_port;
    assign wrap = poll_en && cnt == CW'(POLL_PERIOD - 1);
    assign last_idx = idx == 8'(POLL_CNT - 1);
    assign last_port = item_port == PW'(NPORT - 1);
    assign item_valid = sweep_pend;
    assign item_addr = POLL_BASE + idx;
    // a wrap while a sweep is still running is dropped, never queued
    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            cnt <= '0;
            idx <= '0;
            item_port <= '0;
            sweep_pend <= 1'b0;
        end else begin
            cnt <= (!poll_en || wrap) ? '0 : cnt + 1'b1;
            if (sweep_abort) begin
                sweep_pend <= 1'b0;
                idx <= '0;
                item_port <= '0;
            end else if (item_take) begin
                idx <= last_idx ? '0 : idx + 1'b1;
                if (last_idx) item_port <= last_port ? '0 : item_port + 1'b1;
                if (last_idx && last_port) sweep_pend <= 1'b0;
            end else if (wrap) begin
                sweep_pend <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/mac_mgnt_sched.sv
// mac_mgnt_sched: one-at-a-time arbiter of MAC register access for host and stats poller
module mac_mgnt_sched import mac_mgnt_pkg::*; #(
    parameter int NPORT = 4,
    parameter int PW = 2,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter logic [7:0] POLL_BASE = 8'h00,
    parameter int POLL_CNT = 4,
    parameter int POLL_PERIOD = DEF_POLL_PERIOD
) (
    input logic clk,
    input logic rstn_sys,
    mac_mgnt_sched_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t state;
    req_t req;
    logic [PW-1:0] sel, item_port, gport;
    logic [7:0] addr, item_addr, gaddr, rdata, fin_data;
    logic wr, last_host, item_valid, grant_host, grant_poll, go_issue, legal;
    logic hit, tmo, fin, fin_err, to_host;
    logic [TW-1:0] timer;
    logic [2**PW-1:0] legal_map;

    for (genvar i = 0; i < 2**PW; i++) begin : g_legal
        assign legal_map[i] = i < NPORT;
    end

    mac_mgnt_poll_seq #(
        .NPORT(NPORT), .PW(PW), .POLL_BASE(POLL_BASE),
        .POLL_CNT(POLL_CNT), .POLL_PERIOD(POLL_PERIOD)
    ) u_poll (
        .clk(clk),
        .rstn_sys(rstn_sys),
        .poll_en(bus.poll_en),
        .item_take(grant_poll),
        .sweep_abort(!bus.poll_en),
        .item_valid(item_valid),
        .item_port(item_port),
        .item_addr(item_addr)
    );

    // with both pending, whoever was not served last wins
    assign grant_host = state == IDLE && bus.host_req_valid && (!item_valid || !last_host);
    assign grant_poll = state == IDLE && item_valid && !grant_host;
    assign bus.host_req_ready = grant_host;
    assign legal = legal_map[bus.host_req_port];
    assign go_issue = grant_poll || (grant_host && legal);
    assign gport = grant_host ? bus.host_req_port : item_port;
    assign gaddr = grant_host ? bus.host_req_addr : item_addr;
    assign hit = state == WAIT && bus.sys_resp_valid[sel];
    assign rdata = bus.sys_resp_data[sel*8 +: 8];
    assign tmo = state == WAIT && timer == TW'(TIMEOUT - 1);
    assign fin = (state == ISSUE && wr) || hit || tmo || (grant_host && !legal);
    assign fin_data = hit ? rdata : 8'h00;
    assign fin_err = (tmo && !hit) || state == IDLE;
    assign to_host = state == IDLE || req == REQ_HOST;

    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state <= IDLE;
            req <= REQ_HOST;
            sel <= '0;
            addr <= 8'h00;
            wr <= 1'b0;
            last_host <= 1'b0;
            timer <= '0;
            bus.host_resp_valid <= 1'b0;
            bus.host_resp_data <= 8'h00;
            bus.host_resp_err <= 1'b0;
            bus.poll_valid <= 1'b0;
            bus.poll_port <= '0;
            bus.poll_addr <= 8'h00;
            bus.poll_data <= 8'h00;
            bus.poll_err <= 1'b0;
            bus.sys_req_valid <= '0;
            bus.sys_req_wr <= 1'b0;
            bus.sys_req_addr <= 8'h00;
        end else begin
            bus.host_resp_valid <= fin && to_host;
            bus.host_resp_data <= fin && to_host ? fin_data : 8'h00;
            bus.host_resp_err <= fin && to_host && fin_err;
            bus.poll_valid <= fin && !to_host;
            bus.poll_port <= fin && !to_host ? sel : '0;
            bus.poll_addr <= fin && !to_host ? addr : 8'h00;
            bus.poll_data <= fin && !to_host ? fin_data : 8'h00;
            bus.poll_err <= fin && !to_host && fin_err;
            bus.sys_req_valid <= go_issue ? NPORT'(1) << gport : '0;
            bus.sys_req_wr <= go_issue && grant_host && bus.host_req_wr;
            bus.sys_req_addr <= go_issue ? gaddr : 8'h00;
            timer <= state == WAIT ? timer + 1'b1 : '0;
            unique case (state)
                IDLE: if (grant_host || grant_poll) begin
                    req <= grant_host ? REQ_HOST : REQ_POLL;
                    sel <= gport;
                    addr <= gaddr;
                    wr <= grant_host && bus.host_req_wr;
                    last_host <= grant_host;
                    state <= go_issue ? ISSUE : DONE;
                end
                ISSUE: state <= wr ? DONE : WAIT;
                WAIT: if (hit || tmo) state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
